alu_instr_sequencer: RTL and testbench
======================================

# alu_instr_sequencer

Parametrised control sequencer for the datapath's register-to-register ALU instructions. It replaces the hand-stepped T0–T5 control pattern with a synthesisable Moore FSM covering three phases: fetch (PC to MAR, memory read, MDR to IR), operand staging (Rb to Y, Rc to ALU), and write-back to Ra or to HI/LO. It sits between the memory subsystem and the `Datapath` control inputs, and drives one-hot register select buses sized by parameter. It adds four things the fixed T-state pattern lacks: a memory-ready wait state, a two-cycle HI/LO write-back for mul/div, illegal-opcode abort, and back-to-back instruction issue.

## Interface
- `REG_FIELD_W`, 4: width of each Ra/Rb/Rc field; `NUM_REGS = 2**REG_FIELD_W`.
- `OPCODE_W`, 5: opcode field width; the field occupies `ir[31 -: OPCODE_W]`.
- `OP_MUL`, 5'b01111: opcode that selects HI/LO write-back.
- `OP_DIV`, 5'b10000: opcode that selects HI/LO write-back.
- `OP_ALU_MIN`, 5'b00011 / `OP_ALU_MAX`, 5'b01110: inclusive range of single-result ALU opcodes.
- `clk`  in  1  clock; all state changes occur on the rising edge.
- `clr`  in  1  asynchronous, active-high reset.
- `start`  in  1  request to execute one instruction; sampled in IDLE and in the final write-back state.
- `mem_ready`  in  1  memory read data is valid on `Mdatain`.
- `ir`  in  32  current IR contents from the datapath.
- `PC_out`, `MAR_enable`, `IncPC`, `PC_enable`, `Read`, `MDR_enable`, `MDR_out`, `IR_enable`, `Y_enable`, `Z_enable`, `ZLow_out`, `ZHigh_out`, `LO_enable`, `HI_enable`  out  1 each  datapath strobes.
- `R_out`  out  NUM_REGS  one-hot register-to-bus select.
- `R_enable`  out  NUM_REGS  one-hot register write enable.
- `opcode`  out  OPCODE_W  ALU operation select.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse, asserted in the final write-back state.
- `illegal`  out  1  one-cycle pulse in state ABORT.

## Operation
- Field positions: Ra = `ir[26:23]`, Rb = `ir[22:19]`, Rc = `ir[18:15]`. For REG_FIELD_W > 4 the fields pack downward contiguously from bit `31-OPCODE_W`.
- All outputs are decoded from the registered state only (Moore). Every output is 0 in IDLE and during reset.
- States and the outputs they assert:
  - IDLE: none. Goes to T0 when `start`=1.
  - T0: `PC_out`, `MAR_enable`, `IncPC`, `PC_enable`. Goes to T1.
  - T1: `Read`, `MDR_enable`. Stays in T1 while `mem_ready`=0; goes to T2 on the edge where `mem_ready`=1.
  - T2: `MDR_out`, `IR_enable`. Goes to T3.
  - T3: `R_out[Rb]`, `Y_enable`. If the opcode is not in the ALU range and is not MUL/DIV, goes to ABORT. Otherwise goes to T4.
  - T4: `R_out[Rc]`, `opcode`=`ir[31 -: OPCODE_W]`, `Z_enable`. Goes to T5.
  - T5: `ZLow_out`. For an ALU op also asserts `R_enable[Ra]` and `done`. For MUL/DIV asserts `LO_enable` instead and goes to T6.
  - T6 (MUL/DIV only): `ZHigh_out`, `HI_enable`, `done`.
  - ABORT: `illegal`. Goes to IDLE; no register, HI or LO is written.
- From the final state (T5 for ALU, T6 for MUL/DIV): goes to T0 if `start`=1, otherwise to IDLE. This gives back-to-back issue with no bubble.
- `start` is ignored in all other states.
- `opcode` is 0 in every state except T4.
- Ra = 0 is written like any other register; no special casing.
- At most one bit of `R_out` and at most one bit of `R_enable` is ever high.

## Timing
- `clr` high forces IDLE and all outputs to 0 immediately, without waiting for a clock edge, including mid-instruction. The first state after `clr` falls is IDLE.
- Latency from `start` sampled in IDLE to `done`, with `mem_ready` held at 1:
  - ALU op: T0 through T5, 6 cycles.
  - MUL/DIV: 7 cycles.
  - Each cycle `mem_ready` is low adds one cycle in T1.
- `ir` is first read in T3, i.e. one cycle after the IR load edge. Sequencer behaviour does not depend on `ir` in T0–T2.
- Illegal opcode: `illegal` pulses in the cycle after T3; `busy` falls the following cycle.

## Test plan
- Reset, then `start`=1 with `mem_ready`=1 and `ir`=0x30918000 (OR R1,R2,R3): T3 drives `R_out`=0x0004 with `Y_enable`; T4 drives `R_out`=0x0008 with `opcode`=5'b00110 and `Z_enable`; T5 drives `R_enable`=0x0002 with `ZLow_out`; `done` appears on cycle 6.
- Same instruction with `mem_ready` low for 3 cycles in T1: `Read` and `MDR_enable` stay high for 4 cycles; `done` appears on cycle 9.
- MUL, `ir`={5'b01111, Ra=4, Rb=5, Rc=6, 0}: T5 drives `ZLow_out` and `LO_enable` with `R_enable`=0; T6 drives `ZHigh_out` and `HI_enable`; `done` appears on cycle 7.
- `ir` opcode 5'b11111: `illegal` pulses after T3; `R_enable`, `HI_enable` and `LO_enable` are never asserted; next state is IDLE.
- `start` held high across two ALU instructions: T0 follows T5 directly; two `done` pulses 6 cycles apart.
- `clr` asserted mid-T4 between clock edges: all outputs go to 0 before the next edge; after release, `busy`=0 until a new `start`.

Source files
------------

// File: rtl/alu_instr_sequencer.sv
// Moore control sequencer for register-to-register ALU instructions: fetch, operand staging,
// and write-back to Ra or HI/LO, with a memory-ready wait, illegal-opcode abort and back-to-back issue.
module alu_instr_sequencer #(
    parameter int                   REG_FIELD_W = 4,
    parameter int                   OPCODE_W    = 5,
    parameter logic [OPCODE_W-1:0]  OP_MUL      = 5'b01111,
    parameter logic [OPCODE_W-1:0]  OP_DIV      = 5'b10000,
    parameter logic [OPCODE_W-1:0]  OP_ALU_MIN  = 5'b00011,
    parameter logic [OPCODE_W-1:0]  OP_ALU_MAX  = 5'b01110,
    localparam int                  NUM_REGS    = 2**REG_FIELD_W
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
    input  logic                mem_ready,
    input  logic [31:0]         ir,
    output logic                PC_out,
    output logic                MAR_enable,
    output logic                IncPC,
    output logic                PC_enable,
    output logic                Read,
    output logic                MDR_enable,
    output logic                MDR_out,
    output logic                IR_enable,
    output logic                Y_enable,
    output logic                Z_enable,
    output logic                ZLow_out,
    output logic                ZHigh_out,
    output logic                LO_enable,
    output logic                HI_enable,
    output logic [NUM_REGS-1:0] R_out,
    output logic [NUM_REGS-1:0] R_enable,
    output logic [OPCODE_W-1:0] opcode,
    output logic                busy,
    output logic                done,
    output logic                illegal
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_ABORT = 4'd8
    } state_t;

    localparam int RA_MSB = 31 - OPCODE_W;
    localparam int RB_MSB = RA_MSB - REG_FIELD_W;
    localparam int RC_MSB = RB_MSB - REG_FIELD_W;
    localparam int LO_MSB = RC_MSB - REG_FIELD_W;

    state_t state_q;
    state_t state_d;

    logic [OPCODE_W-1:0]    op_s;
    logic [REG_FIELD_W-1:0] ra_s;
    logic [REG_FIELD_W-1:0] rb_s;
    logic [REG_FIELD_W-1:0] rc_s;
    logic                   is_md_s;
    logic                   is_alu_s;
    logic                   ir_unused_s;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_FIELD_W-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign op_s        = ir[31 -: OPCODE_W];
    assign ra_s        = ir[RA_MSB -: REG_FIELD_W];
    assign rb_s        = ir[RB_MSB -: REG_FIELD_W];
    assign rc_s        = ir[RC_MSB -: REG_FIELD_W];
    assign is_md_s     = (op_s == OP_MUL) || (op_s == OP_DIV);
    assign is_alu_s    = (op_s >= OP_ALU_MIN) && (op_s <= OP_ALU_MAX);
    assign ir_unused_s = ^ir[LO_MSB:0];

    // State register; clr clears it without waiting for a clock edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  begin
                if (start) state_d = S_T0;
                else       state_d = S_IDLE;
            end
            S_T0:    state_d = S_T1;
            S_T1:    begin
                if (mem_ready) state_d = S_T2;
                else           state_d = S_T1;
            end
            S_T2:    state_d = S_T3;
            S_T3:    begin
                if (is_alu_s || is_md_s) state_d = S_T4;
                else                     state_d = S_ABORT;
            end
            S_T4:    state_d = S_T5;
            S_T5:    begin
                if (is_md_s)    state_d = S_T6;
                else if (start) state_d = S_T0;
                else            state_d = S_IDLE;
            end
            S_T6:    begin
                if (start) state_d = S_T0;
                else       state_d = S_IDLE;
            end
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the registered state (Ra/Rb/Rc selects come from the stable IR).
    always_comb begin
        PC_out     = 1'b0;
        MAR_enable = 1'b0;
        IncPC      = 1'b0;
        PC_enable  = 1'b0;
        Read       = 1'b0;
        MDR_enable = 1'b0;
        MDR_out    = 1'b0;
        IR_enable  = 1'b0;
        Y_enable   = 1'b0;
        Z_enable   = 1'b0;
        ZLow_out   = 1'b0;
        ZHigh_out  = 1'b0;
        LO_enable  = 1'b0;
        HI_enable  = 1'b0;
        R_out      = '0;
        R_enable   = '0;
        opcode     = '0;
        busy       = 1'b1;
        done       = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_IDLE:  busy = 1'b0;
            S_T0:    begin
                PC_out     = 1'b1;
                MAR_enable = 1'b1;
                IncPC      = 1'b1;
                PC_enable  = 1'b1;
            end
            S_T1:    begin
                Read       = 1'b1;
                MDR_enable = 1'b1;
            end
            S_T2:    begin
                MDR_out   = 1'b1;
                IR_enable = 1'b1;
            end
            S_T3:    begin
                R_out    = onehot(rb_s);
                Y_enable = 1'b1;
            end
            S_T4:    begin
                R_out    = onehot(rc_s);
                opcode   = op_s;
                Z_enable = 1'b1;
            end
            S_T5:    begin
                ZLow_out = 1'b1;
                if (is_md_s) begin
                    LO_enable = 1'b1;
                end else begin
                    R_enable = onehot(ra_s);
                    done     = 1'b1;
                end
            end
            S_T6:    begin
                ZHigh_out = 1'b1;
                HI_enable = 1'b1;
                done      = 1'b1;
            end
            S_ABORT: illegal = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed bench for alu_instr_sequencer: fetch/stage/write-back sequencing, memory wait,
// MUL HI/LO write-back, illegal abort, back-to-back issue and asynchronous clear.
module tb_alu_instr_sequencer;

    logic        clk;
    logic        clr;
    logic        start;
    logic        mem_ready;
    logic [31:0] ir;
    logic PC_out, MAR_enable, IncPC, PC_enable, Read, MDR_enable, MDR_out, IR_enable;
    logic Y_enable, Z_enable, ZLow_out, ZHigh_out, LO_enable, HI_enable;
    logic [15:0] R_out;
    logic [15:0] R_enable;
    logic [4:0]  opcode;
    logic busy, done, illegal;

    int n_cmp = 0;
    int n_err = 0;
    int n;

    alu_instr_sequencer dut (
        .clk(clk), .clr(clr), .start(start), .mem_ready(mem_ready), .ir(ir),
        .PC_out(PC_out), .MAR_enable(MAR_enable), .IncPC(IncPC), .PC_enable(PC_enable),
        .Read(Read), .MDR_enable(MDR_enable), .MDR_out(MDR_out), .IR_enable(IR_enable),
        .Y_enable(Y_enable), .Z_enable(Z_enable), .ZLow_out(ZLow_out), .ZHigh_out(ZHigh_out),
        .LO_enable(LO_enable), .HI_enable(HI_enable), .R_out(R_out), .R_enable(R_enable),
        .opcode(opcode), .busy(busy), .done(done), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-bit strobes packed for compact comparison.
    localparam int B_PC = 16, B_MAR = 15, B_INC = 14, B_PCE = 13, B_RD = 12, B_MDRE = 11;
    localparam int B_MDRO = 10, B_IRE = 9, B_Y = 8, B_Z = 7, B_ZL = 6, B_ZH = 5, B_LO = 4;
    localparam int B_HI = 3, B_BUSY = 2, B_DONE = 1, B_ILL = 0;

    localparam logic [31:0] E_IDLE = 32'h0;
    localparam logic [31:0] E_T0   = (32'd1 << B_PC) | (32'd1 << B_MAR) | (32'd1 << B_INC)
                                   | (32'd1 << B_PCE) | (32'd1 << B_BUSY);
    localparam logic [31:0] E_T1   = (32'd1 << B_RD) | (32'd1 << B_MDRE) | (32'd1 << B_BUSY);
    localparam logic [31:0] E_T2   = (32'd1 << B_MDRO) | (32'd1 << B_IRE) | (32'd1 << B_BUSY);
    localparam logic [31:0] E_T3   = (32'd1 << B_Y) | (32'd1 << B_BUSY);
    localparam logic [31:0] E_T4   = (32'd1 << B_Z) | (32'd1 << B_BUSY);
    localparam logic [31:0] E_T5A  = (32'd1 << B_ZL) | (32'd1 << B_BUSY) | (32'd1 << B_DONE);
    localparam logic [31:0] E_T5M  = (32'd1 << B_ZL) | (32'd1 << B_LO) | (32'd1 << B_BUSY);
    localparam logic [31:0] E_T6   = (32'd1 << B_ZH) | (32'd1 << B_HI) | (32'd1 << B_BUSY)
                                   | (32'd1 << B_DONE);
    localparam logic [31:0] E_ABT  = (32'd1 << B_ILL) | (32'd1 << B_BUSY);

    localparam logic [31:0] IR_OR  = 32'h3091_8000;
    localparam logic [31:0] IR_MUL = {5'b01111, 4'd4, 4'd5, 4'd6, 15'd0};
    localparam logic [31:0] IR_BAD = {5'b11111, 4'd1, 4'd2, 4'd3, 15'd0};

    logic [31:0] strobes;
    assign strobes = {15'd0, PC_out, MAR_enable, IncPC, PC_enable, Read, MDR_enable, MDR_out,
                      IR_enable, Y_enable, Z_enable, ZLow_out, ZHigh_out, LO_enable, HI_enable,
                      busy, done, illegal};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until done is seen; cnt is the number of steps taken (bounded).
    task automatic wait_done(output int cnt);
        cnt = 0;
        while (done !== 1'b1 && cnt < 20) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; mem_ready = 1'b1; ir = 32'h0;
        #12;
        chk("reset_strobes", strobes, E_IDLE);
        chk("reset_rout", {16'd0, R_out}, 32'h0);
        chk("reset_ren", {16'd0, R_enable}, 32'h0);
        chk("reset_opcode", {27'd0, opcode}, 32'h0);
        clr = 1'b0;
        step();
        chk("idle_after_reset", strobes, E_IDLE);

        // OR R1,R2,R3 with memory always ready.
        ir = IR_OR; start = 1'b1;
        step(); start = 1'b0;
        chk("or_t0", strobes, E_T0);
        step(); chk("or_t1", strobes, E_T1);
        step(); chk("or_t2", strobes, E_T2);
        step(); chk("or_t3", strobes, E_T3);
        chk("or_t3_rout", {16'd0, R_out}, 32'h0004);
        step(); chk("or_t4", strobes, E_T4);
        chk("or_t4_rout", {16'd0, R_out}, 32'h0008);
        chk("or_t4_opcode", {27'd0, opcode}, 32'h06);
        step(); chk("or_t5_done_cycle6", strobes, E_T5A);
        chk("or_t5_ren", {16'd0, R_enable}, 32'h0002);
        chk("or_t5_rout", {16'd0, R_out}, 32'h0);
        chk("or_t5_opcode", {27'd0, opcode}, 32'h0);
        step(); chk("or_idle", strobes, E_IDLE);

        // Same instruction with three not-ready cycles in T1.
        start = 1'b1;
        step(); start = 1'b0;
        step(); mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wait_t1_hold", strobes, E_T1);
            step();
        end
        chk("wait_t1_last", strobes, E_T1);
        mem_ready = 1'b1;
        step(); chk("wait_t2", strobes, E_T2);
        wait_done(n);
        chk("wait_done_latency", 32'(6 + n), 32'd9);
        chk("wait_ren", {16'd0, R_enable}, 32'h0002);
        step(); chk("wait_idle", strobes, E_IDLE);

        // MUL R4,R5,R6: two-cycle LO then HI write-back.
        ir = IR_MUL; start = 1'b1;
        step(); start = 1'b0;
        step(); step();
        step(); chk("mul_t3_rout", {16'd0, R_out}, 32'h0020);
        step(); chk("mul_t4_rout", {16'd0, R_out}, 32'h0040);
        chk("mul_t4_opcode", {27'd0, opcode}, 32'h0F);
        step(); chk("mul_t5", strobes, E_T5M);
        chk("mul_t5_ren", {16'd0, R_enable}, 32'h0);
        step(); chk("mul_t6_done_cycle7", strobes, E_T6);
        chk("mul_t6_ren", {16'd0, R_enable}, 32'h0);
        step(); chk("mul_idle", strobes, E_IDLE);

        // Illegal opcode aborts after T3 without any write enable.
        ir = IR_BAD; start = 1'b1;
        step(); start = 1'b0;
        step(); step();
        step(); chk("bad_t3", strobes, E_T3);
        step(); chk("bad_abort", strobes, E_ABT);
        chk("bad_abort_ren", {16'd0, R_enable}, 32'h0);
        step(); chk("bad_idle", strobes, E_IDLE);

        // Back-to-back ALU issue with start held high.
        ir = IR_OR; start = 1'b1;
        step();
        wait_done(n);
        chk("b2b_first_latency", 32'(1 + n), 32'd6);
        step(); chk("b2b_t0_follows_t5", strobes, E_T0);
        wait_done(n);
        chk("b2b_done_spacing", 32'(1 + n), 32'd6);
        start = 1'b0;
        step(); chk("b2b_idle", strobes, E_IDLE);

        // Asynchronous clear in the middle of T4.
        start = 1'b1;
        step(); start = 1'b0;
        step(); step(); step(); step();
        chk("clr_pre_t4", strobes, E_T4);
        #2; clr = 1'b1; #1;
        chk("clr_async_strobes", strobes, E_IDLE);
        chk("clr_async_rout", {16'd0, R_out}, 32'h0);
        chk("clr_async_opcode", {27'd0, opcode}, 32'h0);
        step();
        clr = 1'b0;
        step(); chk("clr_release_idle", strobes, E_IDLE);
        step(); chk("clr_stays_idle", strobes, E_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
